// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard serial transmit path: transmitter state
// encoding, default system clock and the bit-period divisor helper.
package kbd_pkg;

  localparam int DEFAULT_CLK_HZ = 25000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Clocks per serial bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with registered read data; dout holds the
// popped word from the cycle after the pop onwards.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == (AW + 1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_reg;
  assign level   = level_reg;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        dout_reg   <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW + 1)'(1);
        2'b01:   level_reg <= level_reg - (AW + 1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/kbd_tx_queue.sv
// Keyboard byte queue feeding an 8N1 serial transmitter; host xoff pauses
// transmission between frames only.
module kbd_tx_queue
  import kbd_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   xoff,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg;
  logic             tx_reg, tx_next;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign tx        = tx_reg;
  assign busy      = (state_reg != ST_IDLE) || (level != '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
      // FIFO read data lands one cycle after the pop, i.e. in the first START cycle.
      if (state_reg == ST_START && cnt_reg == '0) begin
        shift_reg <= fifo_dout;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    fifo_pop   = 1'b0;
    tx_next    = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !xoff) begin
          state_next = ST_START;
          fifo_pop   = 1'b1;
          cnt_next   = '0;
        end
      end
      ST_START: begin
        tx_next = 1'b0;
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_DATA;
          cnt_next   = '0;
          bit_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DATA: begin
        tx_next = shift_reg[bit_reg];
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
